// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: time-multiplexed scan of a 4:1 mux.
// Each enabled channel gets a DIV-cycle slot. The first BLANK cycles of a slot
// are blanked while the mux settles. The mux output is captured on the last
// cycle of the slot.
module mux_scan_ctrl #(
    parameter int unsigned DIV   = 1000,
    parameter int unsigned BLANK = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] mask,
    input  logic       mux_out,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic [3:0] samples,
    output logic       slot_tick
);

    localparam int unsigned KW = (DIV > 2) ? $clog2(DIV) : 1;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t          state, state_n;
    logic [KW-1:0]   k, k_n;
    logic [1:0]      sel_n;
    logic [1:0]      next_sel;
    logic [1:0]      low_sel;
    logic [3:0]      an_n;
    logic [3:0]      samples_n;
    logic            tick_n;

    // Next enabled channel above sel (wrapping); nearest offset wins, else hold sel
    always_comb begin
        next_sel = sel;
        for (int unsigned i = 0; i < 3; i++) begin
            if (mask[sel + 2'(3 - i)]) begin
                next_sel = sel + 2'(3 - i);
            end
        end
    end

    // Lowest enabled channel, used on entry to SCAN
    always_comb begin
        low_sel = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (mask[3 - i]) begin
                low_sel = 2'(3 - i);
            end
        end
    end

    // Next-state logic. an and slot_tick are decoded from the next state here,
    // so the registered outputs line up with the k and sel they describe.
    always_comb begin
        state_n   = state;
        k_n       = k;
        sel_n     = sel;
        an_n      = '1;
        samples_n = samples;
        tick_n    = 1'b0;
        case (state)
            IDLE: begin
                k_n = '0;
                if (en && mask != '0) begin
                    state_n = SCAN;
                    sel_n   = low_sel;
                end
            end
            SCAN: begin
                if (!en || mask == '0) begin
                    state_n = IDLE;
                    k_n     = '0;
                end else if (!mask[sel]) begin
                    k_n   = '0;
                    sel_n = next_sel;
                end else if (k == KW'(DIV - 1)) begin
                    samples_n[sel] = mux_out;
                    k_n            = '0;
                    sel_n          = next_sel;
                end else begin
                    k_n = k + 1'b1;
                    if (k_n >= KW'(BLANK)) begin
                        an_n = ~(4'b0001 << sel);
                    end
                    tick_n = (k_n == KW'(DIV - 1));
                end
            end
            default: begin
                state_n = IDLE;
                k_n     = '0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            sel       <= 2'b00;
            an        <= '1;
            samples   <= '0;
            slot_tick <= 1'b0;
        end else begin
            state     <= state_n;
            k         <= k_n;
            sel       <= sel_n;
            an        <= an_n;
            samples   <= samples_n;
            slot_tick <= tick_n;
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed literal checks plus a randomized run
// compared every cycle against a slot-level behavioural model.
module tb_mux_scan_ctrl;

    localparam int DIV   = 8;
    localparam int BLANK = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] mask = 4'b0000;
    logic       mux_out = 1'b0;
    logic [1:0] sel;
    logic [3:0] an;
    logic [3:0] samples;
    logic       slot_tick;

    int total = 0;
    int bad   = 0;
    bit live  = 1'b0;

    // model: is a scan active, position in slot, channel, captured values
    bit       m_act  = 1'b0;
    int       m_pos  = 0;
    int       m_sel  = 0;
    bit [3:0] m_samp = 4'b0000;

    logic [1:0] prev_sel;
    logic       prev_tick;

    mux_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk(clk), .rst(rst), .en(en), .mask(mask), .mux_out(mux_out),
        .sel(sel), .an(an), .samples(samples), .slot_tick(slot_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int next_ch(input int s, input logic [3:0] m);
        for (int d = 1; d <= 4; d++) if (m[(s + d) % 4]) return (s + d) % 4;
        return s;
    endfunction

    // Behavioural model: advance one clock using the inputs sampled on this edge
    always @(posedge clk) begin
        if (rst) begin
            m_act = 0; m_pos = 0; m_sel = 0; m_samp = 4'b0000;
        end else if (!m_act) begin
            if (en && mask != 0) begin
                m_act = 1; m_pos = 0; m_sel = lowest(mask);
            end
        end else if (!en || mask == 0) begin
            m_act = 0; m_pos = 0;
        end else if (!mask[m_sel]) begin
            m_pos = 0; m_sel = next_ch(m_sel, mask);
        end else if (m_pos == DIV - 1) begin
            m_samp[m_sel] = mux_out;
            m_pos = 0; m_sel = next_ch(m_sel, mask);
        end else begin
            m_pos++;
        end
    end

    // Compare process: model vs DUT plus invariants, mid-cycle
    always @(negedge clk) begin
        if (live) begin
            logic [3:0] exp_an;
            exp_an = (m_act && m_pos >= BLANK) ? ~(4'b0001 << m_sel) : 4'b1111;
            chk("sel", {2'b00, sel}, 4'(m_sel));
            chk("an", an, exp_an);
            chk("samples", samples, m_samp);
            chk("slot_tick", {3'b000, slot_tick}, {3'b000, (m_act && m_pos == DIV - 1)});
            chk("an_onehot", {3'b000, ($countones(~an) <= 1)}, 4'd1);
            chk("tick_double", {3'b000, (slot_tick && prev_tick)}, 4'd0);
            if (sel !== prev_sel) chk("an_on_sel_change", an, 4'b1111);
        end
        prev_sel  = sel;
        prev_tick = slot_tick;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(2);
        live = 1'b1;
        rst = 1'b0;
        // reset state
        chk("rst_sel", {2'b00, sel}, 4'd0);
        chk("rst_an", an, 4'b1111);
        chk("rst_samples", samples, 4'b0000);
        chk("rst_tick", {3'b000, slot_tick}, 4'd0);

        // full-mask scan with mux_out=1
        en = 1'b1; mask = 4'b1111; mux_out = 1'b1;
        cyc(1);  // k=0
        chk("s0_k0_an", an, 4'b1111);
        chk("s0_k0_sel", {2'b00, sel}, 4'd0);
        cyc(1);  // k=1
        chk("s0_k1_an", an, 4'b1111);
        cyc(1);  // k=2
        chk("s0_k2_an", an, 4'b1110);
        cyc(5);  // k=7
        chk("s0_k7_an", an, 4'b1110);
        chk("s0_k7_tick", {3'b000, slot_tick}, 4'd1);
        cyc(1);  // slot 1, k=0
        chk("s1_sel", {2'b00, sel}, 4'd1);
        chk("s1_samples", samples, 4'b0001);
        chk("s1_tick", {3'b000, slot_tick}, 4'd0);
        cyc(24); // slot 4 wraps to channel 0
        chk("s4_sel", {2'b00, sel}, 4'd0);
        chk("s4_samples", samples, 4'b1111);

        // reset mid-slot at k=5 on channel 2
        cyc(16 + 5);
        chk("mid_sel", {2'b00, sel}, 4'd2);
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_sel", {2'b00, sel}, 4'd0);
        chk("mid_rst_an", an, 4'b1111);
        chk("mid_rst_samples", samples, 4'b0000);
        chk("mid_rst_tick", {3'b000, slot_tick}, 4'd0);
        rst = 1'b0;

        // alternating pair and single channel patterns
        mask = 4'b1010;
        for (int i = 0; i < 40; i++) begin mux_out = 1'($urandom); cyc(1); end
        mask = 4'b0100;
        for (int i = 0; i < 40; i++) begin mux_out = 1'($urandom); cyc(1); end

        // abort: clear mask[2] at k=4 of a channel-2 slot
        mask = 4'b1111; en = 1'b0; cyc(1); en = 1'b1;
        cyc(1 + 16 + 4);
        chk("abort_pre_sel", {2'b00, sel}, 4'd2);
        mask = 4'b1011;
        cyc(1);
        chk("abort_sel", {2'b00, sel}, 4'd3);
        chk("abort_an", an, 4'b1111);
        chk("abort_tick", {3'b000, slot_tick}, 4'd0);

        // randomized run
        for (int i = 0; i < 4000; i++) begin
            mux_out = 1'($urandom);
            if ($urandom_range(0, 29) == 0) mask = 4'($urandom);
            if ($urandom_range(0, 59) == 0) en = ~en;
            rst = ($urandom_range(0, 299) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter DIV, default 1000, clock cycles per channel slot; legal range DIV >= BLANK+2.
REQ-002 Parameter BLANK, default 2, blanking cycles at start of each slot; legal range BLANK >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  scan enable.
REQ-006 mask  input  4  per-channel enable; bit i includes channel i in the scan.
REQ-007 mux_out  input  1  output of the downstream 4:1 mux, selected by sel.
REQ-008 sel  output  2  registered channel select driving the 4:1 mux.
REQ-009 an  output  4  registered active-low one-hot channel strobe; 4'b1111 = none.
REQ-010 samples  output  4  registered per-channel captured mux_out values.
REQ-011 slot_tick  output  1  one-cycle pulse marking a completed, sampled slot.

Function
REQ-012 States SHALL be IDLE and SCAN; slot cycle counter k SHALL run 0..DIV-1 within SCAN.
REQ-013 IDLE: an=4'b1111, slot_tick=0, k=0, sel and samples hold.
REQ-014 IDLE->SCAN when en=1 and mask!=0; next cycle k=0, sel=lowest set mask bit.
REQ-015 SCAN, k<BLANK: an=4'b1111 (blanking while mux settles).
REQ-016 SCAN, BLANK<=k<=DIV-1: an[sel]=0, other an bits 1.
REQ-017 At k=DIV-1: slot_tick=1 that cycle; samples[sel] captures mux_out on that edge; other samples bits hold.
REQ-018 After k=DIV-1: k=0, sel advances to next set mask bit above sel, wrapping 3->0; single set bit keeps sel unchanged.
REQ-019 Next-channel search SHALL use mask as sampled on the advancing edge.
REQ-020 mask[sel] sampled 0 at any k during SCAN (mask!=0): slot aborts; no capture, no slot_tick; next cycle k=0, an=4'b1111, sel=next set bit per REQ-018.
REQ-021 en=0 or mask==0 during SCAN: next cycle IDLE, an=4'b1111, k=0; no capture; samples retained; takes priority over REQ-017/REQ-020.
REQ-022 an SHALL never show two active bits, and SHALL be 4'b1111 on every cycle where sel differs from the previous cycle.
REQ-023 slot_tick SHALL never be high in two consecutive cycles.

Reset
REQ-024 rst=1 on a clock edge: state=IDLE, k=0, sel=2'b00, an=4'b1111, samples=4'b0000, slot_tick=0, regardless of state or k.
REQ-025 rst SHALL take priority over en, mask and all slot events; first SCAN entry after reset follows REQ-014.

Verification (DIV=8, BLANK=2)
REQ-026 Reset mid-slot at k=5, sel=2 -> next cycle sel=0, an=1111, samples=0000, slot_tick=0.
REQ-027 en=1, mask=1111, mux_out=1 -> sel 0,1,2,3,0 every 8 cycles; an=1111 at k=0..1, an=1110 at k=2..7 in slot 0; slot_tick at k=7; samples=1111 after four slots.
REQ-028 mask=1010 -> sel alternates 1,3,1; an only 1101/0111/1111; samples bits 0 and 2 never change.
REQ-029 mask=1111, clear mask[2] at k=4 of channel-2 slot -> abort next cycle, sel=3, k=0, no slot_tick, samples[2] unchanged.
REQ-030 en dropped at k=6 -> IDLE next cycle, an=1111, no capture; en re-raised -> sel=lowest set bit, k=0.
REQ-031 mask=0100 -> sel stays 2, slot_tick every 8 cycles, samples[2] tracks mux_out at k=7.
